// File: rtl/output_layer_backprop_scheduler.sv
// Sequences one training sample's output-layer nodes through the FP32 back-prop point unit
// and gathers the in-order delta/error results, with watchdog and overrun reporting.
module output_layer_backprop_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODES  = 4,
  parameter int WATCHDOG   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [NUM_NODES*DATA_WIDTH-1:0] i_expected_vec,
  input  logic [NUM_NODES*DATA_WIDTH-1:0] i_node_vec,
  input  logic [NUM_NODES*DATA_WIDTH-1:0] i_point_vec,
  output logic                            o_bp_valid,
  output logic [DATA_WIDTH-1:0]           o_bp_expected,
  output logic [DATA_WIDTH-1:0]           o_bp_node,
  output logic [DATA_WIDTH-1:0]           o_bp_point,
  input  logic                            i_bp_valid,
  input  logic [DATA_WIDTH-1:0]           i_bp_delta,
  input  logic [DATA_WIDTH-1:0]           i_bp_error,
  output logic [NUM_NODES*DATA_WIDTH-1:0] o_delta_vec,
  output logic [NUM_NODES*DATA_WIDTH-1:0] o_error_vec,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err_timeout,
  output logic                            o_err_overrun
);

  localparam int VW = NUM_NODES * DATA_WIDTH;
  localparam int CW = $clog2(NUM_NODES + 1);
  localparam int WW = $clog2(WATCHDOG + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NODES - 1);
  localparam logic [CW-1:0] N_CNT    = CW'(NUM_NODES);
  localparam logic [WW-1:0] WD_LAST  = WW'(WATCHDOG - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   iss_q, iss_d;
  logic [CW-1:0]   rx_q, rx_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [VW-1:0]   exp_q, exp_d;
  logic [VW-1:0]   node_q, node_d;
  logic [VW-1:0]   point_q, point_d;
  logic [VW-1:0]   delta_q, delta_d;
  logic [VW-1:0]   error_q, error_d;
  logic            tmo_q, tmo_d;
  logic            ovr_q, ovr_d;
  logic            accept;

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    rx_d    = rx_q;
    wd_d    = wd_q;
    exp_d   = exp_q;
    node_d  = node_q;
    point_d = point_q;
    delta_d = delta_q;
    error_d = error_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;

    // Results land in arrival order; anything beyond the last slot or outside a run is an overrun.
    accept = i_bp_valid && (state_q == S_ISSUE || state_q == S_DRAIN) && (rx_q < N_CNT);
    if (accept) begin
      delta_d[int'(rx_q)*DATA_WIDTH +: DATA_WIDTH] = i_bp_delta;
      error_d[int'(rx_q)*DATA_WIDTH +: DATA_WIDTH] = i_bp_error;
      rx_d = rx_q + 1'b1;
      wd_d = '0;
    end
    if (i_bp_valid && !accept) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ISSUE;
          exp_d   = i_expected_vec;
          node_d  = i_node_vec;
          point_d = i_point_vec;
          iss_d   = '0;
          rx_d    = '0;
          wd_d    = '0;
          delta_d = '0;
          error_d = '0;
          tmo_d   = 1'b0;
          ovr_d   = i_bp_valid;
        end
      end
      S_ISSUE: begin
        if (iss_q == LAST_IDX) begin
          iss_d   = '0;
          state_d = S_DRAIN;
        end else begin
          iss_d = iss_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!accept) wd_d = wd_q + 1'b1;
        if (rx_q == N_CNT || wd_q == WD_LAST) begin
          state_d = S_DONE;
          tmo_d   = (rx_d != N_CNT);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      rx_q    <= '0;
      wd_q    <= '0;
      exp_q   <= '0;
      node_q  <= '0;
      point_q <= '0;
      delta_q <= '0;
      error_q <= '0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rx_q    <= rx_d;
      wd_q    <= wd_d;
      exp_q   <= exp_d;
      node_q  <= node_d;
      point_q <= point_d;
      delta_q <= delta_d;
      error_q <= error_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // iss_q is parked at 0 outside ISSUE so the selects below always stay in range.
  assign o_bp_valid    = (state_q == S_ISSUE);
  assign o_bp_expected = o_bp_valid ? exp_q[int'(iss_q)*DATA_WIDTH +: DATA_WIDTH]   : '0;
  assign o_bp_node     = o_bp_valid ? node_q[int'(iss_q)*DATA_WIDTH +: DATA_WIDTH]  : '0;
  assign o_bp_point    = o_bp_valid ? point_q[int'(iss_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_delta_vec   = delta_q;
  assign o_error_vec   = error_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_err_timeout = tmo_q;
  assign o_err_overrun = ovr_q;

endmodule

// File: tb/tb_output_layer_backprop_scheduler.sv
// Directed bench for output_layer_backprop_scheduler with a 14-cycle datapath stand-in
// that returns hand-computed results per issued node.
module tb_output_layer_backprop_scheduler;
  localparam int DW = 32;
  localparam int NN = 4;
  localparam int WD = 32;
  localparam int VW = NN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [VW-1:0] i_expected_vec = '0;
  logic [VW-1:0] i_node_vec = '0;
  logic [VW-1:0] i_point_vec = '0;
  logic          o_bp_valid;
  logic [DW-1:0] o_bp_expected, o_bp_node, o_bp_point;
  logic          i_bp_valid;
  logic [DW-1:0] i_bp_delta, i_bp_error;
  logic [VW-1:0] o_delta_vec, o_error_vec;
  logic          o_busy, o_done, o_err_timeout, o_err_overrun;

  int pass_n = 0;
  int fail_n = 0;
  int chk_n  = 0;

  logic [DW-1:0] exp_tab [NN];
  logic [DW-1:0] node_tab[NN];
  logic [DW-1:0] pt_tab  [NN];
  logic [DW-1:0] d_tab   [NN];
  logic [DW-1:0] e_tab   [NN];
  int            drop_idx = -1;
  int            issue_n = 0;

  bit            pv [14];
  bit [DW-1:0]   pd [14];
  bit [DW-1:0]   pe [14];
  logic          inj = 1'b0;
  logic [DW-1:0] inj_d = '0;
  logic [DW-1:0] inj_e = '0;

  assign i_bp_valid = pv[13] | inj;
  assign i_bp_delta = inj ? inj_d : pd[13];
  assign i_bp_error = inj ? inj_e : pe[13];

  output_layer_backprop_scheduler #(.DATA_WIDTH(DW), .NUM_NODES(NN), .WATCHDOG(WD)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_expected_vec(i_expected_vec), .i_node_vec(i_node_vec), .i_point_vec(i_point_vec),
    .o_bp_valid(o_bp_valid), .o_bp_expected(o_bp_expected), .o_bp_node(o_bp_node),
    .o_bp_point(o_bp_point), .i_bp_valid(i_bp_valid), .i_bp_delta(i_bp_delta),
    .i_bp_error(i_bp_error), .o_delta_vec(o_delta_vec), .o_error_vec(o_error_vec),
    .o_busy(o_busy), .o_done(o_done), .o_err_timeout(o_err_timeout),
    .o_err_overrun(o_err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    chk_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Datapath stand-in: captures each issue mid-cycle, checks its operands, returns the table result 14 cycles on.
  always @(negedge clk) begin
    for (int i = 13; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
      pe[i] = pe[i-1];
    end
    pv[0] = 1'b0;
    pd[0] = '0;
    pe[0] = '0;
    if (i_start && !o_busy) issue_n = 0;
    if (o_bp_valid) begin
      if (issue_n < NN) begin
        check("issue_data", {o_bp_expected, o_bp_node, o_bp_point},
              {exp_tab[issue_n], node_tab[issue_n], pt_tab[issue_n]});
        pv[0] = (issue_n != drop_idx);
        pd[0] = d_tab[issue_n];
        pe[0] = e_tab[issue_n];
      end else begin
        check("issue_count", issue_n, NN - 1);
      end
      issue_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input int k, input logic [DW-1:0] e, input logic [DW-1:0] n,
                      input logic [DW-1:0] p, input logic [DW-1:0] d, input logic [DW-1:0] r);
    exp_tab[k] = e; node_tab[k] = n; pt_tab[k] = p; d_tab[k] = d; e_tab[k] = r;
  endtask

  function automatic logic [VW-1:0] pack(input logic [DW-1:0] t [NN]);
    logic [VW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = t[k];
    return v;
  endfunction

  task automatic start_run();
    i_expected_vec = pack(exp_tab);
    i_node_vec     = pack(node_tab);
    i_point_vec    = pack(pt_tab);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!o_done && c < budget) begin
      tick();
      c++;
    end
    check("done_seen", o_done, 1'b1);
  endtask

  task automatic fill_nominal();
    for (int k = 0; k < NN; k++)
      fill(k, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h3F800000);
  endtask

  task automatic fill_ordered();
    fill(0, 32'h0, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000);
    fill(1, 32'h0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40800000);
    fill(2, 32'h0, 32'h40400000, 32'h40000000, 32'h40400000, 32'h40C00000);
    fill(3, 32'h0, 32'h40800000, 32'h40000000, 32'h40800000, 32'h41000000);
  endtask

  localparam logic [VW-1:0] NOM_D = {4{32'h3F000000}};
  localparam logic [VW-1:0] NOM_E = {4{32'h3F800000}};
  localparam logic [VW-1:0] ORD_D = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [VW-1:0] ORD_E = {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000};
  localparam logic [VW-1:0] TMO_D = {32'h0, 32'h40800000, 32'h40000000, 32'h3F800000};
  localparam logic [VW-1:0] TMO_E = {32'h0, 32'h41000000, 32'h40800000, 32'h40000000};

  initial begin
    int c;
    // Reset state
    tick();
    tick();
    check("rst_ctrl", {o_bp_valid, o_busy, o_done, o_err_timeout, o_err_overrun}, 5'b0);
    check("rst_bp_data", {o_bp_expected, o_bp_node, o_bp_point}, '0);
    check("rst_delta", o_delta_vec, '0);
    check("rst_error", o_error_vec, '0);
    rst_n = 1'b1;
    tick();

    // Nominal run with back-to-back issue
    fill_nominal();
    drop_idx = -1;
    start_run();
    check("nom_busy", o_busy, 1'b1);
    for (int i = 0; i < NN; i++) begin
      check("nom_issue_valid", o_bp_valid, 1'b1);
      tick();
    end
    check("nom_issue_end", {o_bp_valid, o_bp_expected, o_bp_node, o_bp_point}, '0);
    wait_done(60, c);
    check($sformatf("nom_latency_%0d", c + NN), (c + NN >= NN + 14) && (c + NN <= NN + 16), 1'b1);
    check("nom_delta", o_delta_vec, NOM_D);
    check("nom_error", o_error_vec, NOM_E);
    check("nom_flags", {o_err_timeout, o_err_overrun}, 2'b00);
    tick();
    check("nom_after_done", {o_done, o_busy}, 2'b00);

    // Per-node ordering
    fill_ordered();
    start_run();
    wait_done(80, c);
    check("ord_delta", o_delta_vec, ORD_D);
    check("ord_error", o_error_vec, ORD_E);
    check("ord_timeout", o_err_timeout, 1'b0);
    tick();

    // Timeout: third result never returns
    drop_idx = 2;
    start_run();
    wait_done(120, c);
    check($sformatf("tmo_latency_%0d", c), (c >= 45) && (c <= 53), 1'b1);
    check("tmo_flag", o_err_timeout, 1'b1);
    check("tmo_delta", o_delta_vec, TMO_D);
    check("tmo_error", o_error_vec, TMO_E);
    tick();
    check("tmo_sticky", {o_busy, o_err_timeout}, 2'b01);
    drop_idx = -1;

    // Stray result while idle
    inj_d = 32'hDEADBEEF;
    inj_e = 32'hCAFEF00D;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("ovr_flag", o_err_overrun, 1'b1);
    check("ovr_delta_kept", o_delta_vec, TMO_D);
    check("ovr_error_kept", o_error_vec, TMO_E);

    // Start while busy is ignored; new start clears both flags
    start_run();
    check("restart_clear", {o_err_timeout, o_err_overrun}, 2'b00);
    tick();
    i_expected_vec = {4{32'h7F7F7F7F}};
    i_node_vec     = {4{32'h12345678}};
    i_point_vec    = {4{32'h55AA55AA}};
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(80, c);
    check("busy_start_delta", o_delta_vec, ORD_D);
    check("busy_start_error", o_error_vec, ORD_E);
    check("busy_start_flags", {o_err_timeout, o_err_overrun}, 2'b00);
    tick();

    // Reset mid-DRAIN, late results become overruns
    fill_nominal();
    start_run();
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_drain", {o_busy, o_bp_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {o_bp_valid, o_busy, o_done, o_err_timeout, o_err_overrun}, 5'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("late_ovr", {o_busy, o_err_overrun}, 2'b01);
    check("late_delta", o_delta_vec, '0);
    check("late_error", o_error_vec, '0);
    start_run();
    wait_done(60, c);
    check("fresh_delta", o_delta_vec, NOM_D);
    check("fresh_error", o_error_vec, NOM_E);
    check("fresh_flags", {o_err_timeout, o_err_overrun}, 2'b00);
    tick();

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
